// File: rtl/fb_stream_arbiter.sv
// fb_stream_arbiter
//   Sits between the SDRAM controller application port and the framebuffer
//   clients, entirely in the mem_clk domain. It streams the frame out as read
//   bursts, throttled by the video FIFO fill level plus words still in flight.
//   It also packs serial bytes into words and writes each word to the
//   framebuffer as a single-word write. Both streams share the one request port.
//
//   Optional build macro: ARB_STARVE_GUARD_EN
//     When defined, a pending write is forced through after STARVE_MAX
//     consecutive read grants. When undefined, reads have strict priority.
//
// Ports
//   mem_clk, reset       : sole clock; asynchronous active-high reset
//   frame_start          : one-cycle pulse; restarts the read pointer
//   fifo_used            : video FIFO write-side used words
//   sr_data_rdy, sr_data : serial byte strobe and byte
//   mem_req, mem_req_wr_n, mem_req_addr, mem_req_len : request (wr_n 1 = read)
//   mem_ack              : request accepted
//   mem_wr_data, mem_wr_data_next : write word; consumed strobe
//   mem_rd_valid         : one read word delivered to the video FIFO
//   wr_overflow          : sticky, a packed word was dropped
//   frame_done           : every word of the current frame has been requested
module fb_stream_arbiter #(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FIFO_AW     = 8,
  parameter int unsigned FB_BASE     = 0,
  parameter int unsigned FRAME_WORDS = 240000,
  parameter int unsigned WQ_AW       = 2,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              mem_clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [FIFO_AW:0]  fifo_used,
  input  logic              sr_data_rdy,
  input  logic [7:0]        sr_data,
  output logic              mem_req,
  output logic              mem_req_wr_n,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [8:0]        mem_req_len,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_data_next,
  input  logic              mem_rd_valid,
  output logic              wr_overflow,
  output logic              frame_done
);

  localparam int unsigned IW   = FIFO_AW + 2;
  localparam int unsigned NB   = DATA_W / 8;
  localparam int unsigned BC_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WQ_D = 1 << WQ_AW;

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W:0]   END_A  = (ADDR_W + 1)'(FB_BASE + FRAME_WORDS);
  localparam logic [ADDR_W:0]   BL_A   = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [IW-1:0]     BL_I   = IW'(BURST_LEN);
  localparam logic [IW-1:0]     CAP_I  = IW'(1 << FIFO_AW);
  localparam logic [8:0]        LEN_RD = 9'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, WR_DATA} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                wr_n_q, wr_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          len_q, len_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                done_q, done_d;
  logic                fs_pend_q, fs_pend_d;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic [DATA_W-1:0]   pack_q, pack_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic                ovf_q, ovf_d;
  logic [WQ_AW:0]      wq_wp_q, wq_wp_d;
  logic [WQ_AW:0]      wq_rp_q, wq_rp_d;
  logic [DATA_W-1:0]   wq_mem [WQ_D];

  logic                fs_now, eff_done, rd_ok, force_wr;
  logic                rd_grant, wr_grant, rd_acked, pop;
  logic                wq_empty, wq_full, word_done, push_ok, dec;
  logic [ADDR_W-1:0]   eff_rd_ptr;
  logic [ADDR_W:0]     rd_next, wr_next;
  logic [DATA_W-1:0]   word_w;

  assign wq_empty = (wq_wp_q == wq_rp_q);
  assign wq_full  = (wq_wp_q[WQ_AW] != wq_rp_q[WQ_AW]) &&
                    (wq_wp_q[WQ_AW-1:0] == wq_rp_q[WQ_AW-1:0]);

  // A pending or arriving frame_start is folded into the IDLE decision so the
  // restarted pointer and cleared frame_done are used in the same cycle.
  assign fs_now     = fs_pend_q | frame_start;
  assign eff_done   = fs_now ? 1'b0 : done_q;
  assign eff_rd_ptr = fs_now ? BASE_A : rd_ptr_q;
  assign rd_ok      = !eff_done && (({1'b0, fifo_used} + inflight_q + BL_I) <= CAP_I);
  assign rd_next    = {1'b0, rd_ptr_q} + BL_A;
  assign wr_next    = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q, starve_d;

  assign force_wr = (starve_q == SMAX) && !wq_empty;

  always_comb begin
    starve_d = starve_q;
    if (wr_grant)
      starve_d = '0;
    else if (rd_grant && !wq_empty && (starve_q != SMAX))
      starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_wr = 1'b0;
`endif

  // Request FSM and pointers
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wr_n_d    = wr_n_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    done_d    = done_q;
    fs_pend_d = fs_pend_q | frame_start;
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    rd_acked  = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fs_now) begin
          rd_ptr_d  = BASE_A;
          done_d    = 1'b0;
          fs_pend_d = 1'b0;
        end
        if (rd_ok && !force_wr) begin
          state_d  = RD_REQ;
          req_d    = 1'b1;
          wr_n_d   = 1'b1;
          addr_d   = eff_rd_ptr;
          len_d    = LEN_RD;
          rd_grant = 1'b1;
        end else if (!wq_empty) begin
          state_d  = WR_REQ;
          req_d    = 1'b1;
          wr_n_d   = 1'b0;
          addr_d   = wr_ptr_q;
          len_d    = 9'd1;
          wdata_d  = wq_mem[wq_rp_q[WQ_AW-1:0]];
          wr_grant = 1'b1;
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          req_d    = 1'b0;
          state_d  = IDLE;
          rd_acked = 1'b1;
          if (rd_next >= END_A) begin
            rd_ptr_d = BASE_A;
            done_d   = 1'b1;
          end else begin
            rd_ptr_d = rd_next[ADDR_W-1:0];
          end
        end
      end
      WR_REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (mem_wr_data_next) begin
          pop      = 1'b1;
          state_d  = IDLE;
          wr_ptr_d = (wr_next >= END_A) ? BASE_A : wr_next[ADDR_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Inflight accounting, byte packer and write queue
  always_comb begin
    // A valid with nothing outstanding is ignored unless this cycle's ack
    // makes the burst outstanding, in which case the net change applies.
    dec        = mem_rd_valid && (rd_acked || (inflight_q != '0));
    inflight_d = inflight_q + (rd_acked ? BL_I : '0) - (dec ? IW'(1) : '0);

    word_w = pack_q;
    word_w[bcnt_q*8 +: 8] = sr_data;
    word_done = sr_data_rdy && (bcnt_q == BC_W'(NB - 1));
    pack_d = sr_data_rdy ? word_w : pack_q;
    bcnt_d = bcnt_q;
    if (sr_data_rdy)
      bcnt_d = word_done ? '0 : bcnt_q + BC_W'(1);

    // A same-cycle pop frees the head slot; the head word was already
    // captured into the write-data register, so overwriting it is safe.
    push_ok = word_done && (!wq_full || pop);
    ovf_d   = ovf_q | (word_done && !push_ok);
    wq_wp_d = push_ok ? wq_wp_q + (WQ_AW + 1)'(1) : wq_wp_q;
    wq_rp_d = pop     ? wq_rp_q + (WQ_AW + 1)'(1) : wq_rp_q;
  end

  always_ff @(posedge mem_clk) begin
    if (push_ok) wq_mem[wq_wp_q[WQ_AW-1:0]] <= word_w;
  end

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      wr_n_q     <= 1'b1;
      addr_q     <= BASE_A;
      len_q      <= LEN_RD;
      wdata_q    <= '0;
      rd_ptr_q   <= BASE_A;
      wr_ptr_q   <= BASE_A;
      done_q     <= 1'b0;
      fs_pend_q  <= 1'b0;
      inflight_q <= '0;
      pack_q     <= '0;
      bcnt_q     <= '0;
      ovf_q      <= 1'b0;
      wq_wp_q    <= '0;
      wq_rp_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wr_n_q     <= wr_n_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      done_q     <= done_d;
      fs_pend_q  <= fs_pend_d;
      inflight_q <= inflight_d;
      pack_q     <= pack_d;
      bcnt_q     <= bcnt_d;
      ovf_q      <= ovf_d;
      wq_wp_q    <= wq_wp_d;
      wq_rp_q    <= wq_rp_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_req_wr_n = wr_n_q;
  assign mem_req_addr = addr_q;
  assign mem_req_len  = len_q;
  assign mem_wr_data  = wdata_q;
  assign wr_overflow  = ovf_q;
  assign frame_done   = done_q;

endmodule

// File: doc/fb_stream_arbiter.md
Name: fb_stream_arbiter

Overview:
- Parametrised successor to the fixed memrw sequencer between the SDRAM controller application port and the framebuffer clients; runs entirely in the mem_clk domain.
- Streams the frame to the video read FIFO as read bursts, throttled by FIFO fill level.
- Packs serial-port bytes into words and writes them single-word into the framebuffer.
- Arbitrates both request streams onto the one controller request port.

Parameters:
- ADDR_W, 25, application word address width.
- DATA_W, 32, data width; multiple of 8.
- BURST_LEN, 8, read burst length in words; 1..256.
- FIFO_AW, 8, log2 of video FIFO depth.
- FB_BASE, 0, first framebuffer word address.
- FRAME_WORDS, 240000, words per frame; multiple of BURST_LEN.
- WQ_AW, 2, log2 of write-queue depth.
- STARVE_MAX, 4, consecutive read grants before a pending write is forced (feature only).

Ports:
- mem_clk, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high.
- frame_start, in, 1, one-cycle pulse, mem_clk domain; restarts the read pointer.
- fifo_used, in, FIFO_AW+1, video FIFO write-side used words.
- sr_data_rdy, in, 1, serial byte valid strobe.
- sr_data, in, 8, serial byte.
- mem_req, out, 1, request to controller.
- mem_req_wr_n, out, 1, 1=read, 0=write.
- mem_req_addr, out, ADDR_W, request address.
- mem_req_len, out, 9, BURST_LEN for reads, 1 for writes.
- mem_ack, in, 1, request accepted.
- mem_wr_data, out, DATA_W, write word.
- mem_wr_data_next, in, 1, controller consumed mem_wr_data.
- mem_rd_valid, in, 1, one read word delivered to the video FIFO.
- wr_overflow, out, 1, sticky: a packed word was dropped.
- frame_done, out, 1, every word of the current frame has been requested.

Behaviour:
- Reset values:
  - mem_req=0, mem_req_wr_n=1, mem_req_addr=FB_BASE, mem_req_len=BURST_LEN, mem_wr_data=0.
  - wr_overflow=0, frame_done=0.
  - Read and write pointers at FB_BASE; inflight=0; byte packer empty; write queue empty; FSM in IDLE.
- FSM states: IDLE, RD_REQ, WR_REQ, WR_DATA.
- IDLE decision:
  - rd_ok = !frame_done && (fifo_used + inflight + BURST_LEN <= 2^FIFO_AW). Compute at FIFO_AW+2 bits so the sum cannot overflow.
  - If rd_ok: go to RD_REQ. Else if the write queue is non-empty: go to WR_REQ. Otherwise stay in IDLE.
- Request phase:
  - mem_req rises on the edge entering RD_REQ/WR_REQ.
  - mem_req, mem_req_addr, mem_req_len and mem_req_wr_n stay stable until mem_ack is sampled high.
  - mem_req clears on that same edge.
- RD_REQ + mem_ack:
  - inflight += BURST_LEN; read pointer += BURST_LEN; go to IDLE.
  - If the pointer reaches FB_BASE+FRAME_WORDS: wrap it to FB_BASE and set frame_done.
- WR_REQ + mem_ack: go to WR_DATA. mem_wr_data holds the write-queue head from WR_REQ entry.
- WR_DATA + mem_wr_data_next:
  - Pop the queue; write pointer += 1, wrapping at FB_BASE+FRAME_WORDS back to FB_BASE; go to IDLE.
- inflight:
  - Decrements by 1 per mem_rd_valid.
  - On a simultaneous ack and valid, apply the net change (+BURST_LEN-1).
  - A valid while inflight==0 is ignored; inflight saturates at 0.
- frame_start:
  - Latched when it arrives. Applied only in IDLE: read pointer=FB_BASE, frame_done=0.
  - A pulse during RD_REQ takes effect after that request's ack; words already in flight still count.
- Byte packer:
  - Bytes are little-endian: the first byte goes to [7:0].
  - After DATA_W/8 bytes the word is pushed to the write queue.
  - If the queue is full, the word is discarded and wr_overflow is set. Only reset clears wr_overflow.
- Write queue: a push and a pop in the same cycle are both honoured.
- Reset asserted mid-operation: everything returns immediately to reset values. There is no ack or flush handshake with the controller.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter counts read grants made while the write queue is non-empty; it clears on every write grant.
  - When the counter reaches STARVE_MAX, the next IDLE decision grants the write even if rd_ok is true.
- Undefined: strict read priority; the counter is absent.

Test Plan:
- Reset release with fifo_used=0, BURST_LEN=8, FIFO_AW=8 -> 32 read requests at addr 0,8,...,248 with len 8; no 33rd request until mem_rd_valid pulses bring inflight down to 248.
- Serial bytes 0x11,0x22,0x33,0x44, no reads possible (fifo_used=256) -> one write request, addr 0, len 1, wr_n=0, mem_wr_data=0x44332211; write pointer=1 after mem_wr_data_next.
- FRAME_WORDS=16, BURST_LEN=8 -> reads at 0 and 8, then frame_done=1 and no further reads; frame_start pulse -> frame_done=0, next read at addr 0.
- WQ_AW=1, mem_ack held low, 12 bytes sent -> two words queued, third dropped, wr_overflow=1 and stays 1 until reset.
- ARB_STARVE_GUARD_EN, STARVE_MAX=4, rd_ok always true, one word queued -> grant order R,R,R,R,W.
- Reset asserted during WR_DATA -> mem_req=0, queue empty, FSM in IDLE on the same cycle; first request after release is a read at FB_BASE.
